button_event_gen: RTL and testbench

//  Downstream of the button debouncer. Turns one clean, clk-synchronous button level into

---
 rtl/button_event_gen_pkg.sv | 15 +
 rtl/button_event_gen_edge_detect.sv | 29 ++
 rtl/button_event_gen.sv | 129 ++++++++++++
 tb/tb_button_event_gen.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_gen_pkg.sv
// Shared definitions for the button event generator: FSM state encoding and
// default timing constants (100 MHz system clock).
package button_event_gen_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE  = 2'd0,
    BTN_PRESS = 2'd1,
    BTN_LONG  = 2'd2
  } btn_state_t;

  localparam int BTN_LONG_DEF   = 50_000_000;  // 0.5 s hold before long_press
  localparam int BTN_REPEAT_DEF = 10_000_000;  // 0.1 s between repeat pulses
  localparam int BTN_CNT_W_DEF  = 32;

endpackage

// File: rtl/button_event_gen_edge_detect.sv
// Edge detector for a clk-synchronous level. Keeps the previous sample in a
// register and flags rising/falling transitions combinationally against it.
// Usable for any debounced input, not just buttons.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  // Previous-cycle sample of d; cleared by reset so a level already high
  // after reset shows up as a rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of block ordering.
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/button_event_gen.sv
// Button event generator: converts one debounced, clk-synchronous button level
// into single-cycle press / release / long-press / auto-repeat events.
// One shared counter times both the long-press and the repeat phase.
module button_event_gen
  import button_event_gen_pkg::*;
#(
  parameter int LONG_CYCLES   = BTN_LONG_DEF,
  parameter int REPEAT_CYCLES = BTN_REPEAT_DEF,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int CNT_W         = BTN_CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press,
  output logic release_evt,
  output logic release_long,
  output logic long_press,
  output logic repeat_evt,
  output logic held
);

  // Terminal counts below 2 would make PRESS/LONG degenerate.
  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("button_event_gen: LONG_CYCLES and REPEAT_CYCLES must both be >= 2");
  end

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  btn_state_t       state, state_d;
  logic [CNT_W-1:0] counter, counter_d;
  logic             armed;
  logic             rise;
  logic             fall_unused;
  logic             press_d, release_d, release_long_d, long_d, repeat_d;

  edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (btn_in),
    .rise (rise),
    .fall (fall_unused)
  );

  // Arm once the button has been seen released, so a button held through
  // reset cannot generate a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (!btn_in) begin
      armed <= 1'b1;
    end
  end

  // Next-state, counter and event decode. Release is checked first so it
  // masks a coincident long or repeat terminal count.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d        = state;
    counter_d      = counter;
    press_d        = 1'b0;
    release_d      = 1'b0;
    release_long_d = 1'b0;
    long_d         = 1'b0;
    repeat_d       = 1'b0;
    unique case (state)
      BTN_IDLE: begin
        if (armed && rise) begin
          state_d   = BTN_PRESS;
          press_d   = 1'b1;
          counter_d = '0;
        end
      end
      BTN_PRESS: begin
        if (!btn_in) begin
          state_d   = BTN_IDLE;
          release_d = 1'b1;
        end else if (counter == LONG_LAST) begin
          state_d   = BTN_LONG;
          long_d    = 1'b1;
          counter_d = '0;
        end else begin
          counter_d = counter + CNT_W'(1);
        end
      end
      BTN_LONG: begin
        if (!btn_in) begin
          state_d        = BTN_IDLE;
          release_d      = 1'b1;
          release_long_d = 1'b1;
        end else if (REPEAT_EN && counter == REPEAT_LAST) begin
          repeat_d  = 1'b1;
          counter_d = '0;
        end else if (counter != CNT_MAX) begin
          counter_d = counter + CNT_W'(1);
        end
      end
      default: state_d = BTN_IDLE;
    endcase
  end

  // State, counter and all outputs registered together, giving one cycle of
  // latency from the sampled input to every event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BTN_IDLE;
      counter      <= '0;
      press        <= 1'b0;
      release_evt  <= 1'b0;
      release_long <= 1'b0;
      long_press   <= 1'b0;
      repeat_evt   <= 1'b0;
      held         <= 1'b0;
    end else begin
      state        <= state_d;
      counter      <= counter_d;
      press        <= press_d;
      release_evt  <= release_d;
      release_long <= release_long_d;
      long_press   <= long_d;
      repeat_evt   <= repeat_d;
      held         <= (state_d != BTN_IDLE);
    end
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with LONG_CYCLES = 8, REPEAT_CYCLES = 4.
// A second instance with REPEAT_EN = 0 covers the no-repeat configuration.
// Outputs are captured into per-cycle bit masks (bit k = value just after
// clock edge k of the scenario) and compared against hand-computed masks.
module tb_button_event_gen;

  logic clk;
  logic rst;
  logic btn_in;
  logic btn_in2;

  logic press, release_evt, release_long, long_press, repeat_evt, held;
  logic press2, release_evt2, release_long2, long_press2, repeat_evt2, held2;

  int total;
  int bad;

  button_event_gen #(
    .LONG_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .REPEAT_EN     (1'b1),
    .CNT_W         (32)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .press        (press),
    .release_evt  (release_evt),
    .release_long (release_long),
    .long_press   (long_press),
    .repeat_evt   (repeat_evt),
    .held         (held)
  );

  button_event_gen #(
    .LONG_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .REPEAT_EN     (1'b0),
    .CNT_W         (32)
  ) u_dut_norep (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in2),
    .press        (press2),
    .release_evt  (release_evt2),
    .release_long (release_long2),
    .long_press   (long_press2),
    .repeat_evt   (repeat_evt2),
    .held         (held2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive pattern[k] as the level sampled at edge k, log outputs 1 time unit
  // after each edge.
  task automatic capture(input logic [63:0] pattern, input int n, input bit use2,
                         output logic [63:0] mp, output logic [63:0] mr,
                         output logic [63:0] mrl, output logic [63:0] ml,
                         output logic [63:0] mrp, output logic [63:0] mh);
    mp = '0; mr = '0; mrl = '0; ml = '0; mrp = '0; mh = '0;
    if (use2) btn_in2 = pattern[0];
    else      btn_in  = pattern[0];
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (use2) begin
        mp[k] = press2; mr[k] = release_evt2; mrl[k] = release_long2;
        ml[k] = long_press2; mrp[k] = repeat_evt2; mh[k] = held2;
      end else begin
        mp[k] = press; mr[k] = release_evt; mrl[k] = release_long;
        ml[k] = long_press; mrp[k] = repeat_evt; mh[k] = held;
      end
      if (use2) btn_in2 = pattern[k+1];
      else      btn_in  = pattern[k+1];
    end
  endtask

  task automatic test_reset;
    // rst is high from time 0; outputs must be cleared before any clock edge
    #1;
    total++;
    if ({press, release_evt, release_long, long_press, repeat_evt, held} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=000000",
               {press, release_evt, release_long, long_press, repeat_evt, held});
    end
    total++;
    if ({press2, release_evt2, release_long2, long_press2, repeat_evt2, held2} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs_norep got=%b exp=000000",
               {press2, release_evt2, release_long2, long_press2, repeat_evt2, held2});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_short_press;
    logic [63:0] mp, mr, mrl, ml, mrp, mh;
    // high for samples 0..4, low at 5
    capture(64'h1F, 10, 1'b0, mp, mr, mrl, ml, mrp, mh);
    total++; if (mp  !== 64'h1)  begin bad++; $display("FAIL short_press   got=%h exp=%h", mp,  64'h1);  end
    total++; if (mr  !== 64'h20) begin bad++; $display("FAIL short_release got=%h exp=%h", mr,  64'h20); end
    total++; if (mrl !== 64'h0)  begin bad++; $display("FAIL short_rel_long got=%h exp=%h", mrl, 64'h0); end
    total++; if (ml  !== 64'h0)  begin bad++; $display("FAIL short_long    got=%h exp=%h", ml,  64'h0);  end
    total++; if (mh  !== 64'h1F) begin bad++; $display("FAIL short_held    got=%h exp=%h", mh,  64'h1F); end
  endtask

  task automatic test_long_hold;
    logic [63:0] mp, mr, mrl, ml, mrp, mh;
    // high 20 samples: long at 8, repeats at 12 and 16, the terminal count at
    // 20 coincides with release and must not repeat
    capture(64'hFFFFF, 24, 1'b0, mp, mr, mrl, ml, mrp, mh);
    total++; if (mp  !== 64'h1)      begin bad++; $display("FAIL long_press    got=%h exp=%h", mp,  64'h1);      end
    total++; if (ml  !== 64'h100)    begin bad++; $display("FAIL long_long     got=%h exp=%h", ml,  64'h100);    end
    total++; if (mrp !== 64'h11000)  begin bad++; $display("FAIL long_repeat   got=%h exp=%h", mrp, 64'h11000);  end
    total++; if (mr  !== 64'h100000) begin bad++; $display("FAIL long_release  got=%h exp=%h", mr,  64'h100000); end
    total++; if (mrl !== 64'h100000) begin bad++; $display("FAIL long_rel_long got=%h exp=%h", mrl, 64'h100000); end
    total++; if (mh  !== 64'hFFFFF)  begin bad++; $display("FAIL long_held     got=%h exp=%h", mh,  64'hFFFFF);  end
  endtask

  task automatic test_held_through_reset;
    logic [63:0] mp, mr, mrl, ml, mrp, mh;
    @(negedge clk);
    rst = 1'b1;
    btn_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    capture(64'h3FFF_FFFF, 30, 1'b0, mp, mr, mrl, ml, mrp, mh);
    total++;
    if ((mp | mr | mrl | ml | mrp | mh) !== 64'h0) begin
      bad++;
      $display("FAIL held_reset_no_event got=%h exp=%h", mp | mr | mrl | ml | mrp | mh, 64'h0);
    end
    // low at sample 0 arms, high at 1..3 presses, low at 4 releases
    capture(64'hE, 8, 1'b0, mp, mr, mrl, ml, mrp, mh);
    total++; if (mp !== 64'h2)  begin bad++; $display("FAIL held_reset_press   got=%h exp=%h", mp, 64'h2);  end
    total++; if (mr !== 64'h10) begin bad++; $display("FAIL held_reset_release got=%h exp=%h", mr, 64'h10); end
    total++; if (mh !== 64'hE)  begin bad++; $display("FAIL held_reset_held    got=%h exp=%h", mh, 64'hE);  end
  endtask

  task automatic test_release_on_terminal;
    logic [63:0] mp, mr, mrl, ml, mrp, mh;
    // drop at sample 8, the long terminal count
    capture(64'hFF, 12, 1'b0, mp, mr, mrl, ml, mrp, mh);
    total++; if (mr  !== 64'h100) begin bad++; $display("FAIL tc_long_release  got=%h exp=%h", mr,  64'h100); end
    total++; if (mrl !== 64'h0)   begin bad++; $display("FAIL tc_long_rel_long got=%h exp=%h", mrl, 64'h0);   end
    total++; if (ml  !== 64'h0)   begin bad++; $display("FAIL tc_long_long     got=%h exp=%h", ml,  64'h0);   end
    total++; if (mh  !== 64'hFF)  begin bad++; $display("FAIL tc_long_held     got=%h exp=%h", mh,  64'hFF);  end
    // drop at sample 12, the first repeat terminal count
    capture(64'hFFF, 16, 1'b0, mp, mr, mrl, ml, mrp, mh);
    total++; if (ml  !== 64'h100)  begin bad++; $display("FAIL tc_rep_long     got=%h exp=%h", ml,  64'h100);  end
    total++; if (mrp !== 64'h0)    begin bad++; $display("FAIL tc_rep_repeat   got=%h exp=%h", mrp, 64'h0);    end
    total++; if (mr  !== 64'h1000) begin bad++; $display("FAIL tc_rep_release  got=%h exp=%h", mr,  64'h1000); end
    total++; if (mrl !== 64'h1000) begin bad++; $display("FAIL tc_rep_rel_long got=%h exp=%h", mrl, 64'h1000); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] mp, mr, mrl, ml, mrp, mh;
    // high 0..2, low 3, high again 4..6, low 7
    capture(64'h77, 10, 1'b0, mp, mr, mrl, ml, mrp, mh);
    total++; if (mp !== 64'h11) begin bad++; $display("FAIL b2b_press   got=%h exp=%h", mp, 64'h11); end
    total++; if (mr !== 64'h88) begin bad++; $display("FAIL b2b_release got=%h exp=%h", mr, 64'h88); end
    total++; if (mh !== 64'h77) begin bad++; $display("FAIL b2b_held    got=%h exp=%h", mh, 64'h77); end
  endtask

  task automatic test_reset_mid_long;
    logic [63:0] mp, mr, mrl, ml, mrp, mh;
    btn_in = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    total++;
    if (held !== 1'b1) begin bad++; $display("FAIL mid_long_held_before got=%b exp=1", held); end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({press, release_evt, release_long, long_press, repeat_evt, held} !== 6'b0) begin
      bad++;
      $display("FAIL mid_long_async_clear got=%b exp=000000",
               {press, release_evt, release_long, long_press, repeat_evt, held});
    end
    btn_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    capture(64'h0, 6, 1'b0, mp, mr, mrl, ml, mrp, mh);
    total++;
    if ((mp | mr | mrl | ml | mrp | mh) !== 64'h0) begin
      bad++;
      $display("FAIL mid_long_no_release got=%h exp=%h", mp | mr | mrl | ml | mrp | mh, 64'h0);
    end
  endtask

  task automatic test_no_repeat;
    logic [63:0] mp, mr, mrl, ml, mrp, mh;
    capture(64'hFF_FFFF_FFFF, 44, 1'b1, mp, mr, mrl, ml, mrp, mh);
    total++; if (mp  !== 64'h1)           begin bad++; $display("FAIL norep_press    got=%h exp=%h", mp,  64'h1);           end
    total++; if (ml  !== 64'h100)         begin bad++; $display("FAIL norep_long     got=%h exp=%h", ml,  64'h100);         end
    total++; if (mrp !== 64'h0)           begin bad++; $display("FAIL norep_repeat   got=%h exp=%h", mrp, 64'h0);           end
    total++; if (mr  !== 64'h100_0000_0000) begin bad++; $display("FAIL norep_release  got=%h exp=%h", mr,  64'h100_0000_0000); end
    total++; if (mrl !== 64'h100_0000_0000) begin bad++; $display("FAIL norep_rel_long got=%h exp=%h", mrl, 64'h100_0000_0000); end
    total++; if (mh  !== 64'hFF_FFFF_FFFF)  begin bad++; $display("FAIL norep_held     got=%h exp=%h", mh,  64'hFF_FFFF_FFFF);  end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    btn_in  = 1'b0;
    btn_in2 = 1'b0;
    test_reset();
    test_short_press();
    test_long_hold();
    test_back_to_back();
    test_release_on_terminal();
    test_held_through_reset();
    test_reset_mid_long();
    test_no_repeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached without finishing");
    $fatal(1, "timeout");
  end

endmodule
